// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM states (IDLE, REQ, ISSUE, HALT, FAULT)
//   INSTR_W       : instruction word width
//   PC_STEP       : sequential PC increment in bytes
//   TYPE_BRANCH   : instruction[27:26] encoding of the branch class
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ISSUE = 3'd2,
        HALT  = 3'd3,
        FAULT = 3'd4
    } fetch_state_e;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned PC_STEP     = 4;
    localparam logic [1:0]  TYPE_BRANCH = 2'b11;

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts consecutive REQ cycles that see no memory ack and
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES.
// Ports:
//   clock, rst_n : clock, asynchronous active-low reset
//   clear_i      : hold the counter at zero (fetch FSM is not in REQ)
//   count_i      : REQ cycle without ack
//   expire_o     : this cycle completes TIMEOUT_CYCLES unanswered REQ cycles
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    // At least 8 bits, wider if the timeout needs it.
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of unanswered cycles already seen, so the
    // current unanswered cycle is the TIMEOUT_CYCLES-th when cnt_q is one short.
    assign expire_o = count_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, fetches one word at a
// time over a req/ack handshake and presents it to the decoder, then picks
// the next PC from the decoder's branch / link / halt outputs.
// Ports:
//   clock, rst_n             : clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata  : instruction memory handshake (addr == pc)
//   instruction, instr_valid : registered instruction to the decoder
//   should_branch(_to_link), cond_pass, branch_target, link_value :
//                              redirect controls from decoder/datapath
//   halt_temporarily_signal, peripheral_signal : halt request / release
//   pc, pc_plus4             : current PC and its sequential successor
//   fetch_error              : sticky fetch timeout
// Optional: define FETCH_TIMEOUT_EN to enable the REQ watchdog and FAULT
// state; otherwise REQ waits indefinitely and fetch_error is tied low.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instruction,
    output logic                instr_valid,
    input  logic                should_branch,
    input  logic                should_branch_to_link,
    input  logic                cond_pass,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic [ADDR_W-1:0]   link_value,
    input  logic                halt_temporarily_signal,
    input  logic                peripheral_signal,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4,
    output logic                fetch_error
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  seq_pc, redirect_pc;
    logic               timeout_hit;

    assign seq_pc      = pc_q + ADDR_W'(PC_STEP);
    // Misaligned targets are truncated to a word boundary.
    assign redirect_pc = should_branch_to_link ?
                         {link_value[ADDR_W-1:2], 2'b00} :
                         {branch_target[ADDR_W-1:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .rst_n    (rst_n),
        .clear_i  (state_q != REQ),
        .count_i  ((state_q == REQ) && !imem_ack),
        .expire_o (timeout_hit)
    );
    // FAULT is left only through reset, so the state itself is the sticky flag.
    assign fetch_error = (state_q == FAULT);
`else
    assign timeout_hit = 1'b0;
    assign fetch_error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (timeout_hit) begin
                    state_d = FAULT;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Halt wins unless the peripheral is already releasing it.
                if (halt_temporarily_signal && !peripheral_signal) begin
                    state_d = HALT;
                end else if (should_branch && cond_pass) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else begin
                    pc_d    = seq_pc;
                    state_d = REQ;
                end
            end
            HALT: begin
                if (peripheral_signal) begin
                    pc_d    = seq_pc;
                    state_d = REQ;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign instr_valid = (state_q == ISSUE) || (state_q == HALT);
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A directed vector table
// walks the redirect/halt/wrap cases, then a randomized run is compared with
// a transaction-level model of the next-PC rules, followed by async reset and
// timeout (or no-timeout) sequences.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        should_branch = 1'b0;
    logic        should_branch_to_link = 1'b0;
    logic        cond_pass = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] link_value = '0;
    logic        halt_temporarily_signal = 1'b0;
    logic        peripheral_signal = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_error;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    fetch_unit #(
        .ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(10)
    ) dut (
        .clock(clock), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid),
        .should_branch(should_branch), .should_branch_to_link(should_branch_to_link),
        .cond_pass(cond_pass), .branch_target(branch_target), .link_value(link_value),
        .halt_temporarily_signal(halt_temporarily_signal),
        .peripheral_signal(peripheral_signal),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_error(fetch_error)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0C00_1234;
    endfunction

    assign imem_rdata = memword(imem_addr);

    // Next fetch address after the instruction at cur, from the fetch rules.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic sb,
        input logic sbl, input logic cp, input logic [31:0] tgt, input logic [31:0] lnk,
        input logic h, input logic p);
        logic [31:0] t;
        if (h && !p) return cur + 32'd4;        // resumes sequentially after halt
        if (sb && cp) begin
            t = sbl ? lnk : tgt;
            return t - (t % 32'd4);
        end
        return cur + 32'd4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        chk("req_arrives", imem_req, 1);
    endtask

    task automatic fetch(input logic [31:0] a, input int waits);
        wait_req();
        chk("imem_addr", imem_addr, a);
        for (int i = 0; i < waits; i++) begin
            step();
            chk("req_held", imem_req, 1);
            chk("addr_stable", imem_addr, a);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("issue_valid", instr_valid, 1);
        chk("instruction", instruction, memword(a));
        chk("pc", pc, a);
        chk("pc_plus4", pc_plus4, a + 32'd4);
    endtask

    task automatic issue(input logic [31:0] cur, input logic sb, input logic sbl,
        input logic cp, input logic [31:0] tgt, input logic [31:0] lnk,
        input logic h, input logic p, input int hold);
        should_branch = sb; should_branch_to_link = sbl; cond_pass = cp;
        branch_target = tgt; link_value = lnk;
        halt_temporarily_signal = h; peripheral_signal = p;
        step();
        should_branch = 0; should_branch_to_link = 0; cond_pass = 0;
        halt_temporarily_signal = 0; peripheral_signal = 0;
        if (h && !p) begin
            // Branch inputs asserted while halted must have no effect.
            should_branch = 1; cond_pass = 1; branch_target = 32'h0000_0900;
            for (int i = 0; i <= hold; i++) begin
                chk("halt_no_req", imem_req, 0);
                chk("halt_valid", instr_valid, 1);
                chk("halt_instr", instruction, memword(cur));
                chk("halt_pc", pc, cur);
                if (i < hold) step();
            end
            peripheral_signal = 1;
            step();
            peripheral_signal = 0; should_branch = 0; cond_pass = 0;
        end
        chk("req_after_issue", imem_req, 1);
        chk("valid_drop", instr_valid, 0);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_error", fetch_error, 0);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        sb, sbl, cp;
        logic [31:0] tgt, lnk;
        logic        h, p;
        int          hold;
        int          waits;
        logic [31:0] exp_next;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] cur;
        logic [31:0] w, tgt, lnk, exp_n;
        logic sb, sbl, cp, h, p;
        int n;

        //        sb sbl cp  tgt            lnk           h  p  hold waits exp_next
        tbl[0]  = '{0, 0, 0, 32'h0,         32'h0,        0, 0, 0,   0,    32'h4};
        tbl[1]  = '{0, 0, 0, 32'h0,         32'h0,        0, 0, 0,   0,    32'h8};
        tbl[2]  = '{0, 0, 0, 32'h0,         32'h0,        0, 0, 0,   0,    32'hC};
        tbl[3]  = '{1, 0, 1, 32'h103,       32'h0,        0, 0, 0,   0,    32'h100};
        tbl[4]  = '{1, 0, 0, 32'h500,       32'h0,        0, 0, 0,   2,    32'h104};
        tbl[5]  = '{1, 1, 1, 32'h800,       32'h40,       0, 0, 0,   0,    32'h40};
        tbl[6]  = '{0, 0, 0, 32'h0,         32'h0,        1, 1, 0,   1,    32'h44};
        tbl[7]  = '{1, 0, 1, 32'h22,        32'h0,        0, 0, 0,   0,    32'h20};
        tbl[8]  = '{1, 0, 1, 32'h900,       32'h0,        1, 0, 5,   0,    32'h24};
        tbl[9]  = '{1, 0, 1, 32'hFFFF_FFFE, 32'h0,        0, 0, 0,   0,    32'hFFFF_FFFC};
        tbl[10] = '{0, 0, 0, 32'h0,         32'h0,        0, 0, 0,   0,    32'h0};
        tbl[11] = '{0, 0, 0, 32'h0,         32'h0,        0, 0, 0,   1,    32'h4};

        // Reset with a stray ack held through release: must be ignored in IDLE.
        imem_ack = 1'b1;
        apply_reset();
        #1;
        chk("idle_no_req", imem_req, 0);
        step();
        chk("first_req", imem_req, 1);
        chk("idle_ack_ignored", instr_valid, 0);
        imem_ack = 1'b0;

        // Directed vector table.
        cur = 32'h0;
        for (int i = 0; i < 12; i++) begin
            fetch(cur, tbl[i].waits);
            issue(cur, tbl[i].sb, tbl[i].sbl, tbl[i].cp, tbl[i].tgt, tbl[i].lnk,
                  tbl[i].h, tbl[i].p, tbl[i].hold);
            cur = tbl[i].exp_next;
        end
        wait_req();
        chk("table_final_addr", imem_addr, cur);

        // Randomized run against the next-PC model.
        for (int i = 0; i < 40; i++) begin
            w   = memword(cur);
            sb  = (w[27:26] == TYPE_BRANCH) || ($urandom % 3 == 0);
            sbl = 1'($urandom % 2);
            cp  = 1'($urandom % 2);
            tgt = $urandom;
            lnk = $urandom;
            h   = ($urandom % 6 == 0);
            p   = 1'($urandom % 2);
            exp_n = ref_next(cur, sb, sbl, cp, tgt, lnk, h, p);
            fetch(cur, int'($urandom % 3));
            issue(cur, sb, sbl, cp, tgt, lnk, h, p, int'($urandom % 4));
            cur = exp_n;
        end
        wait_req();
        chk("rand_final_addr", imem_addr, cur);

        // Async reset in the middle of an unanswered request.
        step(); step(); step();
        chk("req_waiting", imem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_drop", imem_req, 0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_valid", instr_valid, 0);
        @(negedge clock);
        rst_n = 1'b1;
        fetch(32'h0, 0);
        issue(32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        fetch(32'h4, 0);

`ifdef FETCH_TIMEOUT_EN
        apply_reset();
        step();
        n = 0;
        while (imem_req && n < 30) begin
            n++;
            step();
        end
        chk("timeout_req_cycles", n, 10);
        chk("timeout_error", fetch_error, 1);
        chk("timeout_no_req", imem_req, 0);
        imem_ack = 1'b1;
        step(); step(); step();
        imem_ack = 1'b0;
        chk("fault_ack_ignored", instr_valid, 0);
        chk("fault_no_req", imem_req, 0);
        chk("fault_sticky", fetch_error, 1);
        apply_reset();
        step();
        chk("fault_reset_req", imem_req, 1);
`else
        apply_reset();
        step();
        repeat (300) step();
        chk("no_timeout_req", imem_req, 1);
        chk("no_timeout_error", fetch_error, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
